// File: rtl/sram_port_scheduler_if.sv
// Request/response bundle between a client and the SRAM port scheduler.
// The client owns the master side; the scheduler owns the slave side.
interface sram_port_scheduler_if;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack;
  logic        busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_ack, rd_data, rd_valid, wr_ack, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_ack, rd_data, rd_valid, wr_ack, busy
  );
endinterface

// File: rtl/sram_port_scheduler.sv
// Single-port async SRAM scheduler: 2-cycle reads, 3-cycle writes, reads win
// arbitration unless a pending write has lost MAX_WAIT times in a row.
module sram_port_scheduler #(
  parameter int MAX_WAIT = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  sram_port_scheduler_if.slave    bus,
  output logic [17:0]             SRAM_ADDR,
  inout  wire  [15:0]             SRAM_DQ,
  output logic                    SRAM_WE_N,
  output logic                    SRAM_OE_N,
  output logic                    SRAM_UB_N,
  output logic                    SRAM_LB_N,
  output logic                    SRAM_CE_N
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   wait_cnt;
  logic            decide, wr_forced, grant_rd, grant_wr;
  logic [15:0]     dq_out;
  logic            dq_oe;
  logic [1:0]      be_q, be_nx;

  // Decision points are the last cycle of every access plus every IDLE cycle,
  // which is what gives back-to-back grants with no bubble.
  assign decide    = (state == IDLE) || (state == RD2) || (state == WR3);
  assign wr_forced = (wait_cnt >= CW'(MAX_WAIT));
  assign grant_wr  = decide && bus.wr_req && (!bus.rd_req || wr_forced);
  assign grant_rd  = decide && bus.rd_req && !grant_wr;
  assign be_nx     = grant_wr ? bus.wr_be : be_q;

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RD2, WR3: state_nx = grant_rd ? RD1 : (grant_wr ? WR1 : IDLE);
      RD1:            state_nx = RD2;
      WR1:            state_nx = WR2;
      WR2:            state_nx = WR3;
      default:        state_nx = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      be_q      <= '0;
    end else begin
      if (grant_rd) SRAM_ADDR <= bus.rd_addr;
      if (grant_wr) begin
        SRAM_ADDR <= bus.wr_addr;
        dq_out    <= bus.wr_data;
        be_q      <= bus.wr_be;
      end
      unique case (state_nx)
        RD1, RD2: begin
          SRAM_CE_N <= 1'b0; SRAM_OE_N <= 1'b0; SRAM_WE_N <= 1'b1;
          SRAM_UB_N <= 1'b0; SRAM_LB_N <= 1'b0; dq_oe     <= 1'b0;
        end
        WR1, WR2, WR3: begin
          SRAM_CE_N <= 1'b0; SRAM_OE_N <= 1'b1; SRAM_WE_N <= (state_nx != WR2);
          SRAM_UB_N <= ~be_nx[1]; SRAM_LB_N <= ~be_nx[0]; dq_oe <= 1'b1;
        end
        default: begin
          SRAM_CE_N <= 1'b1; SRAM_OE_N <= 1'b1; SRAM_WE_N <= 1'b1;
          SRAM_UB_N <= 1'b1; SRAM_LB_N <= 1'b1; dq_oe     <= 1'b0;
        end
      endcase
    end

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      bus.rd_ack   <= 1'b0;
      bus.wr_ack   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      wait_cnt     <= '0;
    end else begin
      bus.rd_ack   <= grant_rd;
      bus.wr_ack   <= grant_wr;
      bus.rd_valid <= (state == RD2);
      if (state == RD2) bus.rd_data <= SRAM_DQ;
      // A write still pending at a decision it did not win must have lost to a read.
      if (decide) begin
        if (grant_wr || !bus.wr_req)         wait_cnt <= '0;
        else if (wait_cnt < CW'(MAX_WAIT))   wait_cnt <= wait_cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_sram_port_scheduler.sv
// Directed and randomized checks of the SRAM port scheduler against an async
// SRAM model and a transaction-level reference of arbitration and memory.
module tb_sram_port_scheduler;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  sram_port_scheduler_if bus();
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic we_n, oe_n, ub_n, lb_n, ce_n;

  sram_port_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n)
  );

  // Async SRAM: drives the bus on a read strobe, latches bytes while WE_N is low.
  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(negedge clk)
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr[5:0]][15:8] <= sram_dq[15:8];
      if (!lb_n) mem[sram_addr[5:0]][7:0]  <= sram_dq[7:0];
    end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    bus.wr_addr = 18'(a); bus.wr_data = d; bus.wr_be = be; bus.wr_req = 1'b1;
    tick();
    chk("wr_ack", bus.wr_ack, 1);
    bus.wr_req = 1'b0;
    ref_mem[a] = merge(ref_mem[a], d, be);
    chk("wr1_we", we_n, 1); chk("wr1_ce", ce_n, 0); chk("wr1_oe", oe_n, 1);
    chk("wr1_dq", sram_dq, d); chk("wr1_addr", sram_addr, 18'(a));
    tick();
    chk("wr2_we", we_n, 0); chk("wr2_ub", ub_n, !be[1]); chk("wr2_lb", lb_n, !be[0]);
    chk("wr2_dq", sram_dq, d); chk("wr2_ack", bus.wr_ack, 0);
    tick();
    chk("wr3_we", we_n, 1); chk("wr3_dq", sram_dq, d);
    tick();
    chk("wr_idle_busy", bus.busy, 0); chk("wr_idle_ce", ce_n, 1);
    chk("wr_idle_addr", sram_addr, 18'(a));
  endtask

  task automatic do_read(input logic [5:0] a);
    bus.rd_addr = 18'(a); bus.rd_req = 1'b1;
    tick();
    chk("rd_ack", bus.rd_ack, 1);
    bus.rd_req = 1'b0;
    chk("rd1_oe", oe_n, 0); chk("rd1_we", we_n, 1); chk("rd1_dq", sram_dq, ref_mem[a]);
    chk("rd1_valid", bus.rd_valid, 0);
    tick();
    chk("rd2_oe", oe_n, 0); chk("rd2_dq", sram_dq, ref_mem[a]); chk("rd2_valid", bus.rd_valid, 0);
    tick();
    chk("rd_valid", bus.rd_valid, 1);
    exp_rd_data = ref_mem[a];
    chk("rd_data", bus.rd_data, exp_rd_data);
    chk("rd_idle_busy", bus.busy, 0);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.busy === 1'b0) break;
    end
    chk(tag, bus.busy, 0);
  endtask

  initial begin
    bus.rd_req = 0; bus.rd_addr = '0; bus.wr_req = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.wr_be = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // reset state
    #1 rst_n = 1'b0;
    #4;
    chk("rst_ce", ce_n, 1); chk("rst_oe", oe_n, 1); chk("rst_we", we_n, 1);
    chk("rst_ub", ub_n, 1); chk("rst_lb", lb_n, 1); chk("rst_addr", sram_addr, 0);
    chk("rst_rd_data", bus.rd_data, 0); chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_ack", bus.rd_ack, 0); chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // full write then read-back, then a lower-byte-only overwrite
    do_write(6'd5, 16'h1234, 2'b11);
    do_read(6'd5);
    do_write(6'd5, 16'hABCD, 2'b01);
    do_read(6'd5);
    chk("byte_merge", bus.rd_data, 16'h12CD);

    // reads held continuously starve a write only MAX_WAIT times
    begin
      int nreads = 0, gap = 0;
      logic got_wr = 1'b0;
      bus.rd_addr = 18'd9; bus.rd_req = 1'b1;
      bus.wr_addr = 18'd7; bus.wr_data = 16'h5A5A; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
      for (int c = 0; c < 200 && !got_wr; c++) begin
        tick();
        if (bus.rd_ack) nreads++;
        if (bus.wr_ack) begin
          got_wr = 1'b1; bus.wr_req = 1'b0;
          ref_mem[7] = merge(ref_mem[7], 16'h5A5A, 2'b11);
        end
      end
      chk("starve_wr_granted", got_wr, 1);
      chk("starve_reads", nreads, MAX_WAIT);
      for (int c = 0; c < 10; c++) begin
        tick(); gap++;
        if (bus.rd_ack) break;
      end
      chk("starve_resume_gap", gap, 3);
      bus.rd_req = 1'b0;
      drain("starve_drain");
      exp_rd_data = ref_mem[9];
      chk("starve_rd_data", bus.rd_data, exp_rd_data);
    end

    // alternating read/write back-to-back
    begin
      int nacks = 0, gap = 0, exp_gap = 2;
      logic [15:0] exp_q[$];
      logic [5:0] a;
      logic [15:0] d;
      logic [1:0] be;
      a = 6'($urandom_range(0, 31));
      bus.rd_addr = 18'(a); bus.rd_req = 1'b1;
      tick();
      chk("alt_first_ack", bus.rd_ack, 1);
      nacks = 1; exp_q.push_back(ref_mem[a]); bus.rd_req = 1'b0;
      a = 6'($urandom_range(0, 31)); d = 16'($urandom); be = 2'($urandom);
      bus.wr_addr = 18'(a); bus.wr_data = d; bus.wr_be = be; bus.wr_req = 1'b1;
      for (int c = 0; c < 60 && nacks < 10; c++) begin
        tick(); gap++;
        chk("alt_busy", bus.busy, 1);
        if (!oe_n) chk("alt_rd_bus", sram_dq, ref_mem[sram_addr[5:0]]);
        if (bus.rd_valid) begin
          chk("alt_rd_q", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_rd_data = exp_q.pop_front();
            chk("alt_rd_data", bus.rd_data, exp_rd_data);
          end
        end
        if (bus.rd_ack || bus.wr_ack) begin
          chk("alt_gap", gap, exp_gap);
          gap = 0; nacks++;
          if (bus.rd_ack) begin
            exp_q.push_back(ref_mem[bus.rd_addr[5:0]]);
            bus.rd_req = 1'b0;
            a = 6'($urandom_range(0, 31)); d = 16'($urandom); be = 2'($urandom);
            bus.wr_addr = 18'(a); bus.wr_data = d; bus.wr_be = be; bus.wr_req = 1'b1;
            exp_gap = 2;
          end else begin
            ref_mem[bus.wr_addr[5:0]] = merge(ref_mem[bus.wr_addr[5:0]], bus.wr_data, bus.wr_be);
            bus.wr_req = 1'b0;
            if (nacks < 10) begin
              bus.rd_addr = 18'($urandom_range(0, 31)); bus.rd_req = 1'b1;
            end
            exp_gap = 3;
          end
        end
      end
      chk("alt_acks", nacks, 10);
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.rd_valid && exp_q.size() > 0) begin
          exp_rd_data = exp_q.pop_front();
          chk("alt_tail_data", bus.rd_data, exp_rd_data);
        end
        if (bus.busy === 1'b0) break;
      end
      chk("alt_drain", bus.busy, 0);
      chk("alt_q_empty", exp_q.size(), 0);
    end

    // reset during WR2: strobes release at once, nothing granted until release
    bus.wr_addr = 18'd40; bus.wr_data = 16'hBEEF; bus.wr_be = 2'b11; bus.wr_req = 1'b1;
    tick();
    chk("mid_wr_ack", bus.wr_ack, 1);
    bus.wr_req = 1'b0;
    tick();
    chk("mid_wr2_we", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we_n, 1); chk("mid_rst_ce", ce_n, 1); chk("mid_rst_oe", oe_n, 1);
    chk("mid_rst_ub", ub_n, 1); chk("mid_rst_lb", lb_n, 1); chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_addr", sram_addr, 0); chk("mid_rst_rd_data", bus.rd_data, 0);
    exp_rd_data = '0;
    bus.rd_addr = 18'd3; bus.rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rst_no_rd_ack", bus.rd_ack, 0); chk("mid_rst_no_wr_ack", bus.wr_ack, 0);
      chk("mid_rst_idle", bus.busy, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("first_grant", bus.rd_ack, 1);
    chk("first_grant_wr_ack", bus.wr_ack, 0);
    bus.rd_req = 1'b0;
    tick(); tick();
    chk("first_grant_valid", bus.rd_valid, 1);
    exp_rd_data = ref_mem[3];
    chk("first_grant_data", bus.rd_data, exp_rd_data);
    drain("mid_drain");

    // randomized traffic against a transaction-level model
    begin
      int skip = 0, lost = 0;
      logic g_rd, g_wr, idle_after, v1 = 0, v2 = 0, exp_valid;
      logic [15:0] d1 = '0, d2 = '0, exp_vd, gd;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (bus.rd_ack) begin
          if ($urandom_range(0, 1) == 0) bus.rd_req = 1'b0;
          else bus.rd_addr = 18'($urandom_range(0, 31));
        end else if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
          bus.rd_addr = 18'($urandom_range(0, 31)); bus.rd_req = 1'b1;
        end else if (bus.rd_req && $urandom_range(0, 19) == 0) bus.rd_req = 1'b0;
        if (bus.wr_ack) begin
          if ($urandom_range(0, 1) == 0) bus.wr_req = 1'b0;
          else begin
            bus.wr_addr = 18'($urandom_range(0, 31)); bus.wr_data = 16'($urandom);
            bus.wr_be = 2'($urandom);
          end
        end else if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
          bus.wr_addr = 18'($urandom_range(0, 31)); bus.wr_data = 16'($urandom);
          bus.wr_be = 2'($urandom); bus.wr_req = 1'b1;
        end else if (bus.wr_req && $urandom_range(0, 19) == 0) bus.wr_req = 1'b0;

        // reads cost 2 cycles, writes 3, an idle decision 1
        g_rd = 1'b0; g_wr = 1'b0; idle_after = 1'b0; gd = '0;
        if (skip == 0) begin
          g_wr = bus.wr_req && (!bus.rd_req || lost >= MAX_WAIT);
          g_rd = bus.rd_req && !g_wr;
          if (g_wr || !bus.wr_req) lost = 0;
          else if (lost < MAX_WAIT) lost++;
          if (g_wr) ref_mem[bus.wr_addr[5:0]] = merge(ref_mem[bus.wr_addr[5:0]], bus.wr_data, bus.wr_be);
          if (g_rd) gd = ref_mem[bus.rd_addr[5:0]];
          skip = g_rd ? 1 : (g_wr ? 2 : 0);
          idle_after = !g_rd && !g_wr;
        end else skip--;
        exp_valid = v2; exp_vd = d2;
        v2 = v1; d2 = d1; v1 = g_rd; d1 = gd;

        tick();
        chk("rnd_rd_ack", bus.rd_ack, g_rd);
        chk("rnd_wr_ack", bus.wr_ack, g_wr);
        chk("rnd_busy", bus.busy, !idle_after);
        chk("rnd_rd_valid", bus.rd_valid, exp_valid);
        if (exp_valid) exp_rd_data = exp_vd;
        chk("rnd_rd_data", bus.rd_data, exp_rd_data);
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      drain("rnd_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
